gcd_engine: RTL
===============

# gcd_engine

Parametrised greatest-common-divisor engine with its own operand datapath, valid/ready handshakes on input and output, and a per-request choice of algorithm: subtractive Euclid or binary (Stein). It replaces the fixed 32-bit register-file-driven GCD controller as the reusable GCD compute block. One request is in flight at a time. Each result is returned with the number of compute cycles it took.

## Interface

- `WIDTH`, default 32: operand and result width.
- `CW`, default 16: width of the cycle counter output.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: engine can accept a request; high only in IDLE.
- `in_a` in WIDTH: operand A, unsigned.
- `in_b` in WIDTH: operand B, unsigned.
- `in_mode` in 1: algorithm select, 0 = subtractive, 1 = binary. Sampled with the operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_gcd` out WIDTH: gcd(A,B). gcd(x,0)=x and gcd(0,0)=0.
- `out_cycles` out CW: number of CALC cycles used, saturating at 2^CW−1.
- `busy` out 1: high in CALC or DONE.

## Operation

**States**
- IDLE: `in_ready`=1.
- CALC: one algorithm step per cycle.
- DONE: `out_valid`=1.

**Accept**
- Occurs when `in_valid && in_ready` at a rising edge.
- Registers A←`in_a`, B←`in_b`, mode←`in_mode`, k←0, cycle count←0.
- Next state is CALC.

**Cycle count**
- Every CALC cycle increments the count by 1, including the terminating cycle.
- The count saturates at all-ones.

**Subtractive step** (evaluated in priority order)
- B==0: result←A; go to DONE.
- A<B: swap A and B.
- Otherwise: A←A−B.

**Binary step** (evaluated in priority order)
- B==0: result←A<<k; go to DONE.
- A==0: result←B<<k; go to DONE.
- A and B both even: A←A>>1, B←B>>1, k←k+1.
- A even only: A←A>>1.
- B even only: B←B>>1.
- Both odd, A≥B: A←(A−B)>>1.
- Both odd, A<B: B←(B−A)>>1.

**Width rules**
- k is clog2(WIDTH)+1 bits wide.
- The shifted result never exceeds the original operands, so there is no overflow.
- All arithmetic is unsigned, at WIDTH bits.

**DONE**
- `out_gcd` and `out_cycles` are held stable.
- On `out_valid && out_ready`, go to IDLE.
- `out_gcd` and `out_cycles` keep their last values until the next result is written.
- A new request cannot be accepted in the same cycle as the output handshake.

**Inputs ignored**
- `in_a`, `in_b` and `in_mode` are ignored outside IDLE.
- `in_valid` held high during CALC or DONE has no effect.

## Timing

**Reset values**
- State is IDLE.
- `in_ready`=1, `out_valid`=0, `busy`=0.
- `out_gcd`=0, `out_cycles`=0.
- Internal A, B and k are 0.

**Reset mid-operation**
- Asserting `rst` in CALC or DONE abandons the request.
- The cycle after the reset edge shows IDLE with all values at reset state.
- No result is produced for the abandoned request.

**Latency**
- The accept edge starts CALC cycle 1.
- After N CALC cycles, `out_valid` rises. That is N+1 cycles after the cycle in which the request was accepted.
- The minimum is N=1, for B==0 on entry.

**Output backpressure**
- `out_valid` stays high, with data unchanged, for as long as `out_ready` is low.

**Throughput**
- Back-to-back requests are separated by at least N+2 cycles: the accept cycle, N CALC cycles, and the DONE/handshake cycle.
- After the output handshake, `in_ready` is high on the following cycle.

**Outputs**
- `in_ready`, `out_valid` and `busy` are decoded from registered state only.
- No combinational path exists from `in_valid` or `out_ready` to any output.

## Test plan

1. (12,8), mode 0 and then mode 1, with `out_ready`=1:
   - Both return `out_gcd`=4 and `out_cycles`=6.
   - `out_valid` rises 7 cycles after the accept cycle.
2. Zero operands:
   - (0,5) mode 0 → 5 with cycles=2.
   - (0,5) mode 1 → 5 with cycles=1.
   - (0,0) in either mode → 0 with cycles=1.
   - (7,0) mode 0 → 7 with cycles=1.
3. WIDTH=8, CW=8:
   - (255,1) mode 0 → gcd 1, with `out_cycles` saturated at 255 (the true count is 257).
   - (255,1) mode 1 → gcd 1 with cycles=9.
4. Backpressure: complete (12,8) with `out_ready` held low for 5 cycles in DONE.
   - `out_valid` stays high and `out_gcd`=4 is held throughout.
   - `in_ready` stays 0 throughout.
   - `in_ready`=1 the cycle after `out_ready` rises.
5. Reset mid-operation: with WIDTH=8, send (255,1) mode 0 and assert `rst` for 1 cycle at CALC cycle 10.
   - The next cycle shows IDLE, `in_ready`=1, `out_valid`=0, and outputs at 0.
   - A following (9,6) mode 1 returns 3.
6. Randomised checks against a reference gcd model:
   - 1000 random operand pairs with random modes, plus random `in_valid`/`out_ready` stalls.
   - All results must match the model.
   - No request may be accepted while `busy` is high.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: valid/ready GCD engine, per-request subtractive or binary (Stein) algorithm, reports compute cycles
module gcd_engine #(
  parameter int WIDTH = 32,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CW-1:0]    out_cycles,
  output logic             busy
);
  localparam int KW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b;
  logic [KW-1:0] k;
  logic mode;
  logic [CW-1:0] cnt, cnt_nx;
  assign cnt_nx = &cnt ? cnt : cnt + 1'b1;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      k <= '0;
      mode <= 1'b0;
      cnt <= '0;
      out_gcd <= '0;
      out_cycles <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a <= in_a;
          b <= in_b;
          mode <= in_mode;
          k <= '0;
          cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          cnt <= cnt_nx;
          // the terminating cycle counts too, so the result carries cnt_nx
          if (b == '0) begin
            out_gcd <= mode ? a << k : a;
            out_cycles <= cnt_nx;
            state <= DONE;
          end else if (!mode) begin
            if (a < b) begin
              a <= b;
              b <= a;
            end else a <= a - b;
          end else if (a == '0) begin
            out_gcd <= b << k;
            out_cycles <= cnt_nx;
            state <= DONE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + 1'b1;
          end else if (!a[0]) a <= a >> 1;
          else if (!b[0]) b <= b >> 1;
          else if (a >= b) a <= (a - b) >> 1;
          else b <= (b - a) >> 1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
